// File: rtl/framebuffer_pkg.sv
// Shared defaults, pixel type, linear-address helper and clear-engine state
// encoding for the multi-channel framebuffer.
package framebuffer_pkg;

  localparam int H_RES_DEF   = 640;
  localparam int V_RES_DEF   = 480;
  localparam int PIXEL_W_DEF = 8;

  typedef logic [PIXEL_W_DEF-1:0] pixel_t;

  typedef enum logic [0:0] {
    CLR_IDLE   = 1'b0,
    CLR_ACTIVE = 1'b1
  } clr_state_t;

  // Row-major linear address of pixel (x, y).
  function automatic int unsigned lin_addr(input int unsigned x,
                                           input int unsigned y,
                                           input int unsigned h_res);
    return y * h_res + x;
  endfunction

endpackage

// File: rtl/framebuffer_mc_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr (wrapping)
// and reports the pointer value that follows that grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] next_ptr
);

  int   idx;
  logic found;

  // Rotating priority search starting at ptr.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        next_ptr   = PW'((idx + 1) % N);
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/framebuffer_mc.sv
// N-channel round-robin write port plus scan-out read port onto a pixel memory.
// Optional hardware clear engine is built when FRAMEBUFFER_CLEAR_EN is defined.
module framebuffer_mc
  import framebuffer_pkg::*;
#(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int N_CH    = 4,
  parameter int X_W     = 10,
  parameter int Y_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       wr_valid,
  output logic [N_CH-1:0]       wr_ready,
  input  logic [N_CH*X_W-1:0]   wr_x,
  input  logic [N_CH*Y_W-1:0]   wr_y,
  input  logic [N_CH*PIXEL_W-1:0] wr_data,
  input  logic [X_W-1:0]        rd_x,
  input  logic [Y_W-1:0]        rd_y,
  output logic [PIXEL_W-1:0]    rd_data,
`ifdef FRAMEBUFFER_CLEAR_EN
  input  logic                  clear_req,
  input  logic [PIXEL_W-1:0]    clear_color,
  output logic                  clear_busy,
`endif
  output logic [15:0]           drop_count
);

  localparam int DEPTH = H_RES * V_RES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PIXEL_W-1:0] mem [DEPTH];

  logic [PW-1:0]      ptr, next_ptr;
  logic [N_CH-1:0]    grant;
  logic               wr_hold, accept, in_range, wr_we, rd_in_range;
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic [PIXEL_W-1:0] sel_data;
  logic [AW-1:0]      wr_addr, rd_addr;

  rr_arbiter #(.N(N_CH), .PW(PW)) u_arb (
    .req      (wr_valid),
    .ptr      (ptr),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  assign wr_ready = (rst_n && !wr_hold) ? grant : {N_CH{1'b0}};
  assign accept   = |wr_ready;

  // Steer the granted channel's coordinates and pixel onto the write port.
  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (wr_ready[i]) begin
        sel_x    = wr_x[i*X_W +: X_W];
        sel_y    = wr_y[i*Y_W +: Y_W];
        sel_data = wr_data[i*PIXEL_W +: PIXEL_W];
      end else begin
        sel_x = sel_x;
      end
    end
  end

  assign in_range    = (32'(sel_x) < H_RES) && (32'(sel_y) < V_RES);
  assign wr_addr     = AW'(lin_addr(32'(sel_x), 32'(sel_y), H_RES));
  assign wr_we       = accept && in_range;
  assign rd_in_range = (32'(rd_x) < H_RES) && (32'(rd_y) < V_RES);
  assign rd_addr     = AW'(lin_addr(32'(rd_x), 32'(rd_y), H_RES));

  // Arbitration pointer advances only past an accepted grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= next_ptr;
    end else begin
      ptr <= ptr;
    end
  end

  // Out-of-range writes complete the handshake but are only counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count <= 16'h0000;
    end else if (accept && !in_range && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'h0001;
    end else begin
      drop_count <= drop_count;
    end
  end

  // Read-before-write: a same-address write lands after the old word is sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_in_range) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

`ifdef FRAMEBUFFER_CLEAR_EN
  clr_state_t         clr_state, clr_next;
  logic [AW-1:0]      clr_addr;
  logic [PIXEL_W-1:0] clr_color;
  logic               clr_last;

  assign wr_hold    = (clr_state == CLR_ACTIVE);
  assign clear_busy = (clr_state == CLR_ACTIVE);
  assign clr_last   = (clr_addr == AW'(DEPTH - 1));

  // Clear FSM state, sweep address and latched fill colour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_state <= CLR_IDLE;
      clr_addr  <= '0;
      clr_color <= '0;
    end else begin
      clr_state <= clr_next;
      if (clr_state == CLR_IDLE && clear_req) begin
        clr_addr  <= '0;
        clr_color <= clear_color;
      end else if (clr_state == CLR_ACTIVE) begin
        clr_addr  <= clr_addr + AW'(1);
      end else begin
        clr_addr  <= clr_addr;
      end
    end
  end

  // Clear FSM next state; requests during a sweep are ignored.
  always_comb begin
    clr_next = clr_state;
    case (clr_state)
      CLR_IDLE:   clr_next = clear_req ? CLR_ACTIVE : CLR_IDLE;
      CLR_ACTIVE: clr_next = clr_last ? CLR_IDLE : CLR_ACTIVE;
      default:    clr_next = CLR_IDLE;
    endcase
  end

  // Memory write port, owned by the clear sweep while it runs.
  always_ff @(posedge clk) begin
    if (rst_n && clr_state == CLR_ACTIVE) begin
      mem[clr_addr] <= clr_color;
    end else if (wr_we) begin
      mem[wr_addr] <= sel_data;
    end
  end
`else
  assign wr_hold = 1'b0;

  // Memory write port.
  always_ff @(posedge clk) begin
    if (wr_we) begin
      mem[wr_addr] <= sel_data;
    end
  end
`endif

endmodule

// File: doc/framebuffer_mc.md
# framebuffer_mc

Parametrised multi-channel framebuffer: N writer channels with valid/ready handshake are round-robin arbitrated onto a single write port of an H_RES×V_RES pixel memory, and one independent read port serves the VGA scan-out. Sits between the drawing engines (sprite, text, line units) and the video output stage. Single clock domain, with an optional hardware clear engine.

## Interface
- H_RES, 640, horizontal resolution in pixels
- V_RES, 480, vertical resolution in pixels
- PIXEL_W, 8, bits per pixel
- N_CH, 4, number of write channels (1..8)
- X_W, 10, x coordinate width
- Y_W, 10, y coordinate width
- clk  in  1  single system clock; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- wr_valid  in  N_CH  per-channel write request
- wr_ready  out  N_CH  per-channel grant; a write transfers when valid&ready
- wr_x  in  N_CH*X_W  packed x coordinates, channel i at [i*X_W +: X_W]
- wr_y  in  N_CH*Y_W  packed y coordinates
- wr_data  in  N_CH*PIXEL_W  packed pixel data
- rd_x  in  X_W  read x coordinate
- rd_y  in  Y_W  read y coordinate
- rd_data  out  PIXEL_W  registered read data
- drop_count  out  16  saturating count of discarded out-of-range writes
- clear_req  in  1  start clear (FRAMEBUFFER_CLEAR_EN only)
- clear_color  in  PIXEL_W  fill value (FRAMEBUFFER_CLEAR_EN only)
- clear_busy  out  1  clear in progress (FRAMEBUFFER_CLEAR_EN only)

## Operation
- Storage: H_RES*V_RES words of PIXEL_W, linear address = y*H_RES + x. Contents not initialised by reset.
- Arbitration: at most one grant per cycle. Round-robin pointer `ptr` (reset 0); grant goes to the first asserted wr_valid at or after ptr, wrapping. On a grant to channel i, ptr <= (i+1) mod N_CH; with no valid, ptr holds.
- wr_ready is combinational from wr_valid and ptr; at most one bit set; ready[i] never asserted without valid[i]. Writers must not make valid depend on ready.
- Bounds: a granted write with x>=H_RES or y>=V_RES is accepted (handshake completes) but not stored; drop_count increments, saturating at 0xFFFF.
- Read: rd_data <= mem[rd_y*H_RES+rd_x] each cycle; out-of-range read coordinates give rd_data = 0.
- Read and write to same address in the same cycle: rd_data returns the old contents.
- Reset values: wr_ready = 0 while rst_n low, rd_data = 0, drop_count = 0, ptr = 0, clear_busy = 0, clear state IDLE.

## Timing
- Write: stored on the edge where valid&ready; visible to a read issued the next cycle (rd_data valid one cycle after that).
- Read latency: 1 cycle, fully pipelined, one read per cycle.
- Write throughput: one pixel per cycle aggregate; with all N_CH valid, each channel is granted once every N_CH cycles.
- Reset mid-operation: pending handshakes are dropped, ptr returns to 0, any clear is aborted (memory partially cleared).

## Configuration
- FRAMEBUFFER_CLEAR_EN defined: clear engine present. FSM IDLE -> CLEAR on clear_req high in IDLE (clear_color latched that edge). In CLEAR: writes latched colour to address 0,1,…,H_RES*V_RES-1, one per cycle; all wr_ready forced 0; clear_busy = 1; clear_req ignored. After writing the last address -> IDLE, clear_busy drops the next cycle. Duration exactly H_RES*V_RES cycles. Reads continue normally during clear.
- Undefined: clear_req, clear_color, clear_busy ports absent; no clear FSM or address counter.

## Structure
- Package framebuffer_pkg: default H_RES/V_RES/PIXEL_W constants, pixel typedef, linear-address function, clear FSM state enum.
- Sub-module rr_arbiter (N parameter): request vector + pointer -> one-hot grant and next pointer.
- Top holds memory array, bounds check, drop counter, read pipeline, clear engine.

## Test plan
- Single channel 2 writes (10,20)=0x5A, then read (10,20) -> rd_data = 0x5A one cycle after read address applied.
- All 4 channels valid continuously from reset -> grants ch0,ch1,ch2,ch3,ch0 in consecutive cycles; ptr wraps.
- Ch1 writes (640,0) and (0,480) -> both handshakes complete, memory unchanged, drop_count = 2; force 65537 drops -> stays 0xFFFF.
- Same-cycle write 0x11 and read at (5,5) holding 0x22 -> rd_data = 0x22, next read -> 0x11.
- With FRAMEBUFFER_CLEAR_EN, H_RES=8,V_RES=4: clear_req with color 0x3C -> clear_busy high exactly 32 cycles, wr_ready all 0 throughout, every pixel reads 0x3C after.
- Assert rst_n low at cycle 10 of a clear -> clear_busy 0, ptr 0, drop_count 0 next cycle; writes accepted immediately after rst_n high.
